// File: rtl/min_scan_accum_pkg.sv
// Shared definitions for the maze-step datapath: default widths, sentinel
// energy and the running-minimum state encoding.
package min_scan_accum_pkg;

    localparam int EW_DEF = 7;
    localparam int PW_DEF = 7;

    localparam logic [EW_DEF-1:0] ENE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/min_select.sv
// Two-input energy comparator: passes the first pair through unless enabled
// and the second pair is not larger, so ties go to the second (newer) pair.
module min_select #(
    parameter int EW = 7,
    parameter int PW = 7
) (
    input  logic [EW-1:0] inene1,
    input  logic [PW-1:0] ud_lr1,
    input  logic [EW-1:0] inene2,
    input  logic [PW-1:0] ud_lr2,
    input  logic          exe,
    output logic [EW-1:0] outene,
    output logic [PW-1:0] out_ud_lr
);

    // NOTE: every output gets a default before the conditional, so no latch is inferred.
    always_comb begin
        outene    = inene1;
        out_ud_lr = ud_lr1;
        if (exe && !(inene1 < inene2)) begin
            outene    = inene2;
            out_ud_lr = ud_lr2;
        end
    end

endmodule

// File: rtl/min_scan_accum.sv
// Running-minimum stage: folds a frame of (energy, plot) candidates and
// presents the frame minimum, candidate count and dead-end flag.
module min_scan_accum
    import min_scan_accum_pkg::*;
#(
    parameter  int N_MAX = 4,
    parameter  int EW    = EW_DEF,
    parameter  int PW    = PW_DEF,
    localparam int CW    = $clog2(N_MAX + 1)
) (
    input  logic          m_clock,
    input  logic          p_reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic          in_last,
    input  logic          in_skip,
    input  logic [EW-1:0] in_ene,
    input  logic [PW-1:0] in_plot,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] out_ene,
    output logic [PW-1:0] out_plot,
    output logic [CW-1:0] out_count,
    output logic          out_none,
    output logic          out_ovf
);

    localparam int            BW        = $clog2(N_MAX + 2);
    localparam logic [EW-1:0] SENTINEL  = '1;
    localparam logic [CW-1:0] CNT_SAT   = CW'(N_MAX);
    localparam logic [BW-1:0] BEATS_N   = BW'(N_MAX);
    localparam logic [BW-1:0] BEATS_SAT = BW'(N_MAX + 1);

    state_e        state_q, state_d;
    logic [EW-1:0] best_ene_q, best_ene_d;
    logic [PW-1:0] best_plot_q, best_plot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [EW-1:0] out_ene_q, out_ene_d;
    logic [PW-1:0] out_plot_q, out_plot_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_none_q, out_none_d;
    logic          out_ovf_q, out_ovf_d;

    logic          xfer, start, fold;
    logic [EW-1:0] base_ene, sel_ene;
    logic [PW-1:0] base_plot, sel_plot;
    logic [CW-1:0] base_cnt;
    logic [BW-1:0] base_beats;

    assign in_ready = !p_reset && (state_q != ST_HOLD);
    assign xfer     = in_valid && in_ready;
    assign fold     = xfer && !in_skip;
    // Any beat accepted in IDLE opens a frame; in ACC only a first-flagged beat restarts.
    assign start    = xfer && ((state_q == ST_IDLE) || in_first);

    assign base_ene   = start ? SENTINEL : best_ene_q;
    assign base_plot  = start ? '0 : best_plot_q;
    assign base_cnt   = start ? '0 : cnt_q;
    assign base_beats = start ? '0 : beats_q;

    min_select #(
        .EW(EW),
        .PW(PW)
    ) u_min_select (
        .inene1    (base_ene),
        .ud_lr1    (base_plot),
        .inene2    (in_ene),
        .ud_lr2    (in_plot),
        .exe       (fold),
        .outene    (sel_ene),
        .out_ud_lr (sel_plot)
    );

    always_comb begin
        state_d     = state_q;
        best_ene_d  = best_ene_q;
        best_plot_d = best_plot_q;
        cnt_d       = cnt_q;
        beats_d     = beats_q;
        out_ene_d   = out_ene_q;
        out_plot_d  = out_plot_q;
        out_count_d = out_count_q;
        out_none_d  = out_none_q;
        out_ovf_d   = out_ovf_q;

        if (xfer) begin
            best_ene_d  = sel_ene;
            best_plot_d = sel_plot;
            cnt_d       = (fold && (base_cnt != CNT_SAT)) ? base_cnt + CW'(1) : base_cnt;
            beats_d     = (base_beats != BEATS_SAT) ? base_beats + BW'(1) : base_beats;
            if (in_last) begin
                state_d     = ST_HOLD;
                out_ene_d   = sel_ene;
                out_plot_d  = sel_plot;
                out_count_d = cnt_d;
                out_none_d  = (cnt_d == '0);
                out_ovf_d   = (beats_d > BEATS_N);
            end else begin
                state_d = ST_ACC;
            end
        end

        if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q     <= ST_IDLE;
            best_ene_q  <= SENTINEL;
            best_plot_q <= '0;
            cnt_q       <= '0;
            beats_q     <= '0;
            out_ene_q   <= SENTINEL;
            out_plot_q  <= '0;
            out_count_q <= '0;
            out_none_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_ene_q  <= best_ene_d;
            best_plot_q <= best_plot_d;
            cnt_q       <= cnt_d;
            beats_q     <= beats_d;
            out_ene_q   <= out_ene_d;
            out_plot_q  <= out_plot_d;
            out_count_q <= out_count_d;
            out_none_q  <= out_none_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_ene   = out_ene_q;
    assign out_plot  = out_plot_q;
    assign out_count = out_count_q;
    assign out_none  = out_none_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_min_scan_accum.sv
// Directed bench for min_scan_accum: expected frame results are queued as
// beats are driven and compared when the stage presents its result.
module tb_min_scan_accum;

    import min_scan_accum_pkg::*;

    localparam logic [6:0] P_U = 7'd1;
    localparam logic [6:0] P_D = 7'd2;
    localparam logic [6:0] P_L = 7'd3;
    localparam logic [6:0] P_R = 7'd4;

    typedef struct {
        logic [6:0] ene;
        logic [6:0] plot;
        logic [2:0] count;
        logic       none;
        logic       ovf;
    } exp_t;

    logic       m_clock;
    logic       p_reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_first;
    logic       in_last;
    logic       in_skip;
    logic [6:0] in_ene;
    logic [6:0] in_plot;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_ene;
    logic [6:0] out_plot;
    logic [2:0] out_count;
    logic       out_none;
    logic       out_ovf;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    min_scan_accum #(
        .N_MAX(4),
        .EW   (7),
        .PW   (7)
    ) dut (
        .m_clock  (m_clock),
        .p_reset  (p_reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_first (in_first),
        .in_last  (in_last),
        .in_skip  (in_skip),
        .in_ene   (in_ene),
        .in_plot  (in_plot),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ene  (out_ene),
        .out_plot (out_plot),
        .out_count(out_count),
        .out_none (out_none),
        .out_ovf  (out_ovf)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic first, input logic last, input logic skip,
                        input logic [6:0] ene, input logic [6:0] plot);
        @(negedge m_clock);
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_skip  = skip;
        in_ene   = ene;
        in_plot  = plot;
    endtask

    task automatic expect_frame(input logic [6:0] ene, input logic [6:0] plot,
                                input logic [2:0] count, input logic none, input logic ovf);
        exp_t e;
        e.ene   = ene;
        e.plot  = plot;
        e.count = count;
        e.none  = none;
        e.ovf   = ovf;
        sb.push_back(e);
    endtask

    task automatic compare_outputs(input string tag, input exp_t e);
        check({tag, ".ene"},   32'(out_ene),   32'(e.ene));
        check({tag, ".plot"},  32'(out_plot),  32'(e.plot));
        check({tag, ".count"}, 32'(out_count), 32'(e.count));
        check({tag, ".none"},  32'(out_none),  32'(e.none));
        check({tag, ".ovf"},   32'(out_ovf),   32'(e.ovf));
    endtask

    // Called right after the last beat is driven; the result must be
    // valid exactly one cycle after that beat transfers.
    task automatic collect(input string tag, input int stall);
        exp_t e;
        @(negedge m_clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e = sb.pop_front();
        check({tag, ".latency_valid"}, 32'(out_valid), 32'd1);
        compare_outputs(tag, e);
        for (int i = 0; i < stall; i++) begin
            @(negedge m_clock);
            check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_ready"}, 32'(in_ready),  32'd0);
            compare_outputs({tag, ".stall"}, e);
        end
        out_ready = 1'b1;
        @(negedge m_clock);
        out_ready = 1'b0;
        check({tag, ".post_ready"}, 32'(in_ready),  32'd1);
        check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".ene"},   32'(out_ene),   32'(ENE_MAX));
        check({tag, ".plot"},  32'(out_plot),  32'd0);
        check({tag, ".count"}, 32'(out_count), 32'd0);
        check({tag, ".none"},  32'(out_none),  32'd0);
        check({tag, ".ovf"},   32'(out_ovf),   32'd0);
    endtask

    initial begin
        p_reset   = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_skip   = 1'b0;
        in_ene    = '0;
        in_plot   = '0;
        out_ready = 1'b0;

        // Reset state, and in_ready forced low while reset is held.
        @(negedge m_clock);
        @(negedge m_clock);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check_reset_values("rst");
        p_reset = 1'b0;
        @(negedge m_clock);
        check("rst.release_ready", 32'(in_ready), 32'd1);

        // Basic frame, minimum in the middle.
        beat(1'b1, 1'b0, 1'b0, 7'd40, P_U);
        beat(1'b0, 1'b0, 1'b0, 7'd25, P_D);
        beat(1'b0, 1'b0, 1'b0, 7'd31, P_L);
        beat(1'b0, 1'b1, 1'b0, 7'd60, P_R);
        expect_frame(7'd25, P_D, 3'd4, 1'b0, 1'b0);
        collect("basic", 0);

        // Tie goes to the newer candidate; output stalled for 5 cycles.
        beat(1'b1, 1'b0, 1'b0, 7'd12, P_U);
        beat(1'b0, 1'b1, 1'b0, 7'd12, P_L);
        expect_frame(7'd12, P_L, 3'd2, 1'b0, 1'b0);
        collect("tie_stall", 5);

        // Dead end: every beat skipped, with noise on the data lines.
        beat(1'b1, 1'b0, 1'b1, 7'd3,  P_U);
        beat(1'b0, 1'b0, 1'b1, 7'd0,  P_D);
        beat(1'b0, 1'b0, 1'b1, 7'd1,  P_L);
        beat(1'b0, 1'b1, 1'b1, 7'd2,  P_R);
        expect_frame(7'd127, 7'd0, 3'd0, 1'b1, 1'b0);
        collect("all_skip", 0);

        // Real candidate at all-ones energy beats the sentinel.
        beat(1'b1, 1'b1, 1'b0, 7'd127, P_R);
        expect_frame(7'd127, P_R, 3'd1, 1'b0, 1'b0);
        collect("max_single", 0);

        // Restart mid-frame discards the partial minimum.
        beat(1'b1, 1'b0, 1'b0, 7'd9,  P_U);
        beat(1'b0, 1'b0, 1'b0, 7'd5,  P_D);
        beat(1'b1, 1'b0, 1'b0, 7'd20, P_L);
        beat(1'b0, 1'b1, 1'b0, 7'd22, P_R);
        expect_frame(7'd20, P_L, 3'd2, 1'b0, 1'b0);
        collect("restart", 0);

        // Frame opened from IDLE without in_first, with a skipped beat inside.
        beat(1'b0, 1'b0, 1'b0, 7'd7, P_D);
        beat(1'b0, 1'b0, 1'b1, 7'd1, P_U);
        beat(1'b0, 1'b1, 1'b0, 7'd9, P_L);
        expect_frame(7'd7, P_D, 3'd2, 1'b0, 1'b0);
        collect("no_first", 0);

        // Overlong frame: count saturates at 4, overflow flagged.
        beat(1'b1, 1'b0, 1'b0, 7'd50, P_U);
        beat(1'b0, 1'b0, 1'b0, 7'd40, P_D);
        beat(1'b0, 1'b0, 1'b0, 7'd30, P_L);
        beat(1'b0, 1'b0, 1'b0, 7'd20, P_R);
        beat(1'b0, 1'b0, 1'b0, 7'd10, P_U);
        beat(1'b0, 1'b1, 1'b0, 7'd60, P_D);
        expect_frame(7'd10, P_U, 3'd4, 1'b0, 1'b1);
        collect("overflow", 0);

        // Reset mid-frame abandons it and clears the held result.
        beat(1'b1, 1'b0, 1'b0, 7'd50, P_U);
        beat(1'b0, 1'b0, 1'b0, 7'd40, P_D);
        @(negedge m_clock);
        in_valid = 1'b0;
        p_reset  = 1'b1;
        @(negedge m_clock);
        check("midrst.in_ready", 32'(in_ready), 32'd0);
        check_reset_values("midrst");
        p_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge m_clock);
            check("midrst.no_valid", 32'(out_valid), 32'd0);
        end
        check("midrst.ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
